// File: rtl/display_scan_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_driver_if
// Description : Bundles the display sources, selects and alarm controls
//               (master -> slave) with the scanned segment bus, digit
//               enables and buzzer (slave -> master).
// Ports       : current_time, alarm_time, key_buffer  - BCD digit sources
//               show_new_time, show_a                  - source selects
//               alarm_enable, alarm_stop               - alarm controls
//               seg, digit_en, sound_alarm             - display / buzzer
// Revision    : 1.0 - initial release
// ============================================================================
interface display_scan_driver_if #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 4
);
  logic [NUM_DIGITS*DIGIT_W-1:0] current_time;
  logic [NUM_DIGITS*DIGIT_W-1:0] alarm_time;
  logic [NUM_DIGITS*DIGIT_W-1:0] key_buffer;
  logic                          show_new_time;
  logic                          show_a;
  logic                          alarm_enable;
  logic                          alarm_stop;
  logic [7:0]                    seg;
  logic [NUM_DIGITS-1:0]         digit_en;
  logic                          sound_alarm;

  modport master (
    output current_time, alarm_time, key_buffer,
    output show_new_time, show_a, alarm_enable, alarm_stop,
    input  seg, digit_en, sound_alarm
  );

  modport slave (
    input  current_time, alarm_time, key_buffer,
    input  show_new_time, show_a, alarm_enable, alarm_stop,
    output seg, digit_en, sound_alarm
  );
endinterface
`default_nettype wire

// File: rtl/display_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_driver
// Description : Time-multiplexed 7-segment driver. Picks key buffer, alarm
//               time or current time, scans one digit per SCAN_DIV cycles,
//               and owns the alarm buzzer (edge-triggered match, timed
//               duration, stop and enable).
// Ports       : clock - system clock, rising edge
//               reset - asynchronous active-low reset
//               bus   - display_scan_driver_if.slave (sources, selects,
//                       alarm controls, seg/digit_en/sound_alarm outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module display_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_W      = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int ALARM_CYCLES = 5000
) (
  input  logic                  clock,
  input  logic                  reset,
  display_scan_driver_if.slave  bus
);

  localparam int PRE_W = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(ALARM_CYCLES + 1);
  localparam int SRC_W = NUM_DIGITS * DIGIT_W;

  logic [PRE_W-1:0]      pre_q,        pre_d;
  logic [IDX_W-1:0]      idx_q,        idx_d;
  logic [7:0]            seg_q,        seg_d;
  logic [NUM_DIGITS-1:0] digit_en_q,   digit_en_d;
  logic                  sound_q,      sound_d;
  logic [CNT_W-1:0]      cnt_q,        cnt_d;
  logic                  match_prev_q, match_prev_d;

  logic                  tick;
  logic [SRC_W-1:0]      src;
  logic                  src_is_alarm;
  logic [DIGIT_W-1:0]    digit;
  logic                  match;

  function automatic logic [6:0] seg7(input logic [DIGIT_W-1:0] v);
    logic [6:0] r;
    case (32'(v))
      0:       r = 7'h3F;
      1:       r = 7'h06;
      2:       r = 7'h5B;
      3:       r = 7'h4F;
      4:       r = 7'h66;
      5:       r = 7'h6D;
      6:       r = 7'h7D;
      7:       r = 7'h07;
      8:       r = 7'h7F;
      9:       r = 7'h6F;
      default: r = 7'h40;  // non-BCD shows a dash
    endcase
    return r;
  endfunction

  // Source selection: key entry overrides alarm view, which overrides time.
  always_comb begin
    src          = bus.current_time;
    src_is_alarm = 1'b0;
    if (bus.show_new_time) begin
      src = bus.key_buffer;
    end else if (bus.show_a) begin
      src          = bus.alarm_time;
      src_is_alarm = 1'b1;
    end
  end

  assign tick  = (pre_q == PRE_W'(SCAN_DIV - 1));
  assign digit = src[idx_q*DIGIT_W +: DIGIT_W];
  assign match = (bus.current_time == bus.alarm_time);

  // Scan path: outputs only change on a tick, so each slot is glitch-free.
  always_comb begin
    pre_d      = tick ? '0 : pre_q + PRE_W'(1);
    idx_d      = idx_q;
    seg_d      = seg_q;
    digit_en_d = digit_en_q;
    if (tick) begin
      digit_en_d = NUM_DIGITS'(1) << idx_q;
      seg_d      = {src_is_alarm && (idx_q == '0), seg7(digit)};
      idx_d      = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Alarm path: clear beats trigger beats countdown. The match history is
  // always updated so a held match can never retrigger.
  always_comb begin
    match_prev_d = match;
    sound_d      = sound_q;
    cnt_d        = cnt_q;
    if (bus.alarm_stop || !bus.alarm_enable) begin
      sound_d = 1'b0;
      cnt_d   = '0;
    end else if (match && !match_prev_q && !sound_q) begin
      sound_d = 1'b1;
      cnt_d   = CNT_W'(ALARM_CYCLES - 1);
    end else if (sound_q) begin
      if (cnt_q == '0) begin
        sound_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pre_q        <= '0;
      idx_q        <= '0;
      seg_q        <= 8'h00;
      digit_en_q   <= '0;
      sound_q      <= 1'b0;
      cnt_q        <= '0;
      // Treat "already matching" as the history so release never triggers.
      match_prev_q <= 1'b1;
    end else begin
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      seg_q        <= seg_d;
      digit_en_q   <= digit_en_d;
      sound_q      <= sound_d;
      cnt_q        <= cnt_d;
      match_prev_q <= match_prev_d;
    end
  end

  assign bus.seg         = seg_q;
  assign bus.digit_en    = digit_en_q;
  assign bus.sound_alarm = sound_q;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_scan_driver
// Description : Self-checking bench for display_scan_driver with a
//               behavioural scan/alarm model and directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scan_driver;

  localparam int NUM_DIGITS   = 4;
  localparam int DIGIT_W      = 4;
  localparam int SCAN_DIV     = 4;
  localparam int ALARM_CYCLES = 10;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  display_scan_driver_if #(.NUM_DIGITS(NUM_DIGITS), .DIGIT_W(DIGIT_W)) bus ();

  display_scan_driver #(
    .NUM_DIGITS  (NUM_DIGITS),
    .DIGIT_W     (DIGIT_W),
    .SCAN_DIV    (SCAN_DIV),
    .ALARM_CYCLES(ALARM_CYCLES)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: cycles since release decide slot timing; the alarm is
  // a count of remaining high cycles.
  logic [6:0] lut [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  int unsigned cyc;
  logic [7:0]  m_seg;
  logic [3:0]  m_en;
  int          m_rem;
  logic        m_prev;

  function automatic int slot_of(int unsigned c);
    return int'((c / SCAN_DIV) % NUM_DIGITS);
  endfunction

  function automatic logic [7:0] model_seg(int slot);
    logic [15:0] s;
    int d;
    logic dp;
    dp = 1'b0;
    if (bus.show_new_time) s = bus.key_buffer;
    else if (bus.show_a) begin s = bus.alarm_time; dp = (slot == 0); end
    else s = bus.current_time;
    d = int'((s >> (4 * slot)) & 16'h000F);
    return {dp, (d < 10) ? lut[d] : 7'h40};
  endfunction

  function automatic logic is_match();
    return bus.current_time == bus.alarm_time;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      cyc <= 0; m_seg <= 8'h00; m_en <= 4'h0; m_rem <= 0; m_prev <= 1'b1;
    end else begin
      cyc <= cyc + 1;
      if ((cyc % SCAN_DIV) == SCAN_DIV - 1) begin
        m_en  <= 4'(1 << slot_of(cyc));
        m_seg <= model_seg(slot_of(cyc));
      end
      m_prev <= is_match();
      if (bus.alarm_stop || !bus.alarm_enable) m_rem <= 0;
      else if (is_match() && !m_prev && m_rem == 0) m_rem <= ALARM_CYCLES;
      else if (m_rem > 0) m_rem <= m_rem - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clock); #1;
    chk("seg_vs_model",      32'(bus.seg),         32'(m_seg));
    chk("digit_en_vs_model", 32'(bus.digit_en),    32'(m_en));
    chk("sound_vs_model",    32'(bus.sound_alarm), 32'(m_rem > 0));
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Advance until the scan newly enters slot k (bounded).
  task automatic wait_slot(input int k);
    logic [3:0] prev;
    int n;
    n = 0;
    do begin
      prev = bus.digit_en;
      cycle();
      n++;
    end while (!(bus.digit_en == 4'(1 << k) && prev != bus.digit_en) &&
               n < 3 * NUM_DIGITS * SCAN_DIV);
    chk($sformatf("slot%0d_reached", k), 32'(bus.digit_en), 32'(1 << k));
  endtask

  initial begin
    bus.current_time  = 16'h1234;
    bus.alarm_time    = 16'h0000;
    bus.key_buffer    = 16'h0000;
    bus.show_new_time = 1'b0;
    bus.show_a        = 1'b0;
    bus.alarm_enable  = 1'b0;
    bus.alarm_stop    = 1'b0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_seg",      32'(bus.seg),         32'h00);
    chk("rst_digit_en", 32'(bus.digit_en),    32'h0);
    chk("rst_sound",    32'(bus.sound_alarm), 32'h0);
    reset = 1'b1;

    // First tick lands on the SCAN_DIV-th edge after release
    cycles(SCAN_DIV - 1);
    chk("pre_tick_digit_en", 32'(bus.digit_en), 32'h0);
    chk("pre_tick_seg",      32'(bus.seg),      32'h00);
    cycle();
    chk("tick0_digit_en", 32'(bus.digit_en), 32'h1);
    chk("tick0_seg",      32'(bus.seg),      32'h66);
    wait_slot(1); chk("time_d1", 32'(bus.seg), 32'h4F);
    wait_slot(2); chk("time_d2", 32'(bus.seg), 32'h5B);
    wait_slot(3); chk("time_d3", 32'(bus.seg), 32'h06);
    wait_slot(0); chk("time_d0_wrap", 32'(bus.seg), 32'h66);
    cycles(2 * NUM_DIGITS * SCAN_DIV);

    // Alarm view: dp on digit 0 only
    bus.show_a = 1'b1; bus.alarm_time = 16'h0730;
    wait_slot(0); chk("alarm_d0_dp", 32'(bus.seg), 32'hBF);
    wait_slot(1); chk("alarm_d1",    32'(bus.seg), 32'h4F);

    // Key buffer wins over alarm select
    bus.show_new_time = 1'b1; bus.key_buffer = 16'h9999;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      wait_slot(k); chk($sformatf("key9_d%0d", k), 32'(bus.seg), 32'h6F);
    end

    // Non-BCD digit renders as a dash
    bus.key_buffer = 16'h0A00;
    wait_slot(2); chk("dash_d2", 32'(bus.seg), 32'h40);

    // Randomised mix of display selects and alarm traffic
    bus.alarm_time = 16'h0700;
    for (int i = 0; i < 400; i++) begin
      bus.show_new_time = ($urandom_range(0, 3) == 0);
      bus.show_a        = $urandom_range(0, 1) == 1;
      bus.key_buffer    = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       bus.current_time = 16'($urandom);
        1:       bus.current_time = 16'h0701;
        default: bus.current_time = 16'h0700;
      endcase
      bus.alarm_enable = ($urandom_range(0, 7) != 0);
      bus.alarm_stop   = ($urandom_range(0, 15) == 0);
      cycle();
    end

    // Directed alarm: clean start
    bus.show_new_time = 1'b0; bus.show_a = 1'b0;
    bus.alarm_enable = 1'b1; bus.alarm_stop = 1'b1;
    bus.current_time = 16'h0659;
    cycle();
    bus.alarm_stop = 1'b0;
    cycles(3);
    bus.current_time = 16'h0700;
    cycle(); chk("alarm_rise", 32'(bus.sound_alarm), 32'h1);
    for (int i = 0; i < ALARM_CYCLES - 1; i++) begin
      cycle(); chk("alarm_hold", 32'(bus.sound_alarm), 32'h1);
    end
    cycle(); chk("alarm_expire", 32'(bus.sound_alarm), 32'h0);
    for (int i = 0; i < 15; i++) begin
      cycle(); chk("no_retrig_held", 32'(bus.sound_alarm), 32'h0);
    end
    bus.current_time = 16'h0701; cycle();
    bus.current_time = 16'h0700;
    cycle(); chk("retrigger", 32'(bus.sound_alarm), 32'h1);

    // Stop on the third sounding cycle
    cycles(2);
    bus.alarm_stop = 1'b1;
    cycle(); chk("stop_clears", 32'(bus.sound_alarm), 32'h0);
    bus.alarm_stop = 1'b0;

    // Stop coincident with the match rise
    bus.current_time = 16'h0701; cycle();
    bus.current_time = 16'h0700; bus.alarm_stop = 1'b1;
    cycle(); chk("stop_at_rise", 32'(bus.sound_alarm), 32'h0);
    bus.alarm_stop = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle(); chk("after_stop_rise", 32'(bus.sound_alarm), 32'h0);
    end

    // Disabled at the match rise
    bus.current_time = 16'h0701; cycle();
    bus.alarm_enable = 1'b0; bus.current_time = 16'h0700;
    cycle(); chk("disabled_rise", 32'(bus.sound_alarm), 32'h0);
    cycles(3);
    bus.alarm_enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle(); chk("reenable_held", 32'(bus.sound_alarm), 32'h0);
    end

    // Reset mid-alarm and mid-scan
    bus.current_time = 16'h0701; cycle();
    bus.current_time = 16'h0700;
    cycle(); chk("pre_reset_sound", 32'(bus.sound_alarm), 32'h1);
    reset = 1'b0;
    #1;
    chk("async_rst_seg",      32'(bus.seg),         32'h00);
    chk("async_rst_digit_en", 32'(bus.digit_en),    32'h0);
    chk("async_rst_sound",    32'(bus.sound_alarm), 32'h0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle(); chk("release_matching", 32'(bus.sound_alarm), 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/display_scan_driver.md
# display_scan_driver

Parametrised, time-multiplexed display driver for the alarm clock; successor to the static per-digit display driver. Selects among current time, alarm time and key buffer and scans them onto a shared 7-segment bus, one digit at a time. It also owns alarm sounding: edge-triggered match detection, timed duration, stop and enable. It sits between the timegen/alarm-register/key-buffer blocks and the board display pins and buzzer.

## Interface
Parameters:
- NUM_DIGITS, 4, digits scanned; index 0 = least-significant digit, bus bits [DIGIT_W-1:0].
- DIGIT_W, 4, BCD width per digit.
- SCAN_DIV, 1000, clock cycles per digit slot; must be ≥ 2.
- ALARM_CYCLES, 5000, cycles sound_alarm stays high once triggered; must be ≥ 1.

Ports:
- clock  in  1  system clock; all state on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- current_time  in  NUM_DIGITS*DIGIT_W  time of day.
- alarm_time  in  NUM_DIGITS*DIGIT_W  stored alarm time.
- key_buffer  in  NUM_DIGITS*DIGIT_W  digits being keyed in.
- show_new_time  in  1  display key_buffer (highest priority).
- show_a  in  1  display alarm_time.
- alarm_enable  in  1  arms the alarm; low forces sound_alarm low.
- alarm_stop  in  1  one-cycle-or-longer stop request.
- seg  out  8  segments, active-high; bit0..bit6 = a..g, bit7 = dp.
- digit_en  out  NUM_DIGITS  one-hot, active-high digit select.
- sound_alarm  out  1  buzzer enable.

## Operation
- Source select per cycle:
  - show_new_time=1 → key_buffer.
  - Else show_a=1 → alarm_time.
  - Else → current_time.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1 and wraps. Tick = prescaler at SCAN_DIV-1.
  - Digit index idx counts 0..NUM_DIGITS-1 and wraps.
  - On tick: digit_en ← one-hot(idx); seg ← encode(selected source digit idx); idx ← idx+1 (wrap).
- Encoding (hex, bits6..0):
  - Digits: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Any value ≥ 10 → 40 ('-').
- dp (seg[7]) is 1 only when the digit loaded is idx 0 and the selected source is alarm_time; otherwise 0.
- Alarm:
  - match = (current_time == alarm_time) over all bits. match_d is the registered match.
  - Trigger condition: match & ~match_d & alarm_enable & ~sound_alarm. On trigger: sound_alarm ← 1, down-counter ← ALARM_CYCLES-1.
  - While sounding, the counter decrements each cycle; at 0, sound_alarm ← 0.
  - Clear conditions (priority over trigger and counting): alarm_stop=1 or alarm_enable=0 → sound_alarm ← 0, counter ← 0.
  - Retrigger requires match to deassert then reassert. Match held steady never retriggers, including after stop or expiry.
- Counter width is $clog2(ALARM_CYCLES+1).

## Timing
- Reset (async assert, sync deassert in the system):
  - prescaler=0, idx=0, seg=8'h00, digit_en=0, sound_alarm=0, counter=0.
  - match_d=1, so an already-matching time at reset release does not trigger.
- First tick is at the SCAN_DIV-th rising edge after reset release. digit_en then becomes one-hot with bit 0 set.
- Each digit is held for exactly SCAN_DIV cycles. A full frame is NUM_DIGITS*SCAN_DIV cycles.
- A source change or select change is sampled only at ticks. Latency is ≤ SCAN_DIV cycles per digit, with no glitch within a slot.
- digit_en is exactly one-hot after the first tick, never all-zero, and never multi-hot.
- Alarm latency:
  - match first true at edge t: sound_alarm high after edge t.
  - Stays high for exactly ALARM_CYCLES cycles absent stop/disable.
- alarm_stop or alarm_enable low sampled at edge t → sound_alarm low after edge t.
- Simultaneous trigger and alarm_stop in the same cycle: stop wins, sound_alarm stays 0. match_d still updates, so no later trigger occurs until match re-rises.
- Reset mid-scan or mid-alarm: all state returns to reset values immediately.

## Test plan
- Reset release with SCAN_DIV=4, NUM_DIGITS=4, current_time=16'h1234, no selects → digit_en 0001/0010/0100/1000 each for 4 cycles, seg 66/4F/5B/06 (digit 0 = '4'), repeating; all outputs 0 before the first tick.
- show_a=1, alarm_time=16'h0730 → digit 0 seg = 8'hBF (3F with dp set); show_new_time=1 together with show_a=1 and key_buffer=16'h9999 → all digits 6F, dp 0.
- Digit value 4'hA in key_buffer digit 2 → seg 40 during slot 2.
- ALARM_CYCLES=10, alarm_enable=1, current_time steps 0659→0700 with alarm_time=0700 → sound_alarm high the next cycle for exactly 10 cycles, then 0 with the match held (no retrigger); stepping to 0701 then back to 0700 retriggers.
- Trigger, then alarm_stop pulse on cycle 3 → sound_alarm low after that edge. Stop on the same cycle as the match rise → never asserts. alarm_enable=0 at match → never asserts.
- Reset asserted mid-alarm and mid-scan → sound_alarm, seg and digit_en are 0 immediately. Release with time already equal to alarm_time → no trigger.
